// File: rtl/halfband_decim_ts.sv
// halfband_decim_ts: time-shared symmetric halfband FIR decimator (decimate by 2).
//
// One multiplier is iterated over the K non-zero symmetric coefficient pairs. The 0.5 centre
// tap is applied by a shift only. Coefficients are loaded at runtime through a small write
// port. One output is produced for every two accepted input samples.
//
// Optional build macro: HB_DECIM_SAT_EN
//   defined   -> the output saturates when the accumulator exceeds the output range
//   undefined -> the output is a plain bit-slice of the accumulator (wraps around)
//
// Ports:
//   sys_clk    system clock
//   reset      synchronous, active-high reset
//   in_en      one-cycle strobe, x_in valid
//   x_in       input sample, signed 1sWIDTH-1
//   coef_wr    coefficient write strobe (ignored while busy)
//   coef_addr  coefficient index 0..K-1 (indices >= K are ignored)
//   coef_data  signed coefficient, 1sCWIDTH-1
//   y          filtered, decimated output, signed; holds its value between strobes
//   y_valid    one-cycle strobe marking a new y
//   busy       high while a computation is in flight (MAC, CTR, OUT)
//   ovf        sticky overrun flag, set by in_en arriving while busy
module halfband_decim_ts #(
  parameter int unsigned WIDTH  = 18,
  parameter int unsigned CWIDTH = 18,
  parameter int unsigned NTAPS  = 11,
  localparam int unsigned K     = (NTAPS + 1) / 4,
  localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              in_en,
  input  logic [WIDTH-1:0]  x_in,
  input  logic              coef_wr,
  input  logic [KW-1:0]     coef_addr,
  input  logic [CWIDTH-1:0] coef_data,
  output logic [WIDTH-1:0]  y,
  output logic              y_valid,
  output logic              busy,
  output logic              ovf
);

  // Pre-add is WIDTH+1 bits, product WIDTH+CWIDTH+1 bits; the accumulator adds headroom for
  // K products plus the centre term.
  localparam int unsigned PW   = WIDTH + CWIDTH + 1;
  localparam int unsigned AW   = PW + $clog2(K + 1);
  localparam int unsigned CTRI = (NTAPS - 1) / 2;
  localparam int unsigned YMSB = WIDTH + CWIDTH - 2;
  localparam int unsigned YLSB = CWIDTH - 1;

  localparam logic [KW-1:0] KLast = KW'(K - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMac  = 2'd1;
  localparam logic [1:0] StCtr  = 2'd2;
  localparam logic [1:0] StOut  = 2'd3;

  // Only lengths of the form 4K-1 have the halfband zero pattern this datapath assumes.
  if (NTAPS < 3 || ((NTAPS + 1) % 4) != 0) begin : g_bad_ntaps
    $error("halfband_decim_ts: NTAPS must equal 4K-1 with K >= 1");
  end

  logic signed [WIDTH-1:0]  x_q [NTAPS];
  logic signed [CWIDTH-1:0] c_q [K];
  logic signed [CWIDTH-1:0] c_d [K];

  logic [1:0]          state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                phase_q, phase_d;
  logic [WIDTH-1:0]    y_q, y_d;
  logic                ovf_q, ovf_d;

  logic                 trigger;
  logic signed [WIDTH-1:0]  xa, xb, xc;
  logic signed [CWIDTH-1:0] cc;
  logic signed [WIDTH:0]    pre;
  logic signed [PW-1:0]     prod;
  logic signed [AW-1:0]     ctr_term;
  logic [WIDTH-1:0]         y_next;

  // Every second accepted sample starts a new output computation.
  assign trigger = in_en & phase_q;
  assign busy    = (state_q != StIdle);
  assign ovf     = ovf_q;

  // A sample landing in the OUT cycle aborts that output, so the strobe is gated by in_en.
  assign y_valid = (state_q == StOut) && !in_en;
  assign y       = y_valid ? y_next : y_q;

  // Select the symmetric tap pair and coefficient for the current MAC step.
  always_comb begin
    xa = x_q[0];
    xb = x_q[NTAPS-1];
    cc = c_q[0];
    for (int i = 0; i < K; i++) begin
      if (k_q == KW'(i)) begin
        xa = x_q[2*i];
        xb = x_q[NTAPS-1-2*i];
        cc = c_q[i];
      end
    end
  end

  always_comb begin
    pre  = $signed({xa[WIDTH-1], xa}) + $signed({xb[WIDTH-1], xb});
    prod = PW'(pre) * PW'(cc);
  end

  // Centre coefficient is exactly 0.5, i.e. 2^(CWIDTH-2) in coefficient units.
  assign xc       = x_q[CTRI];
  assign ctr_term = AW'(xc) <<< (CWIDTH - 2);

`ifdef HB_DECIM_SAT_EN
  logic [AW-1-YMSB:0] acc_top;

  always_comb begin
    acc_top = acc_q[AW-1:YMSB];
    if ((&acc_top) || !(|acc_top)) begin
      y_next = acc_q[YMSB:YLSB];
    end else if (acc_q[AW-1]) begin
      y_next = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      y_next = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  // Slice truncates toward -inf; upper bits are discarded (wrap-around).
  assign y_next = acc_q[YMSB:YLSB];
`endif

  // Coefficient bank: writes only while idle; a write coincident with a trigger is still
  // idle, so the MAC starting next cycle sees the new value.
  always_comb begin
    c_d = c_q;
    if (coef_wr && !busy) begin
      for (int i = 0; i < K; i++) begin
        if (coef_addr == KW'(i)) begin
          c_d[i] = $signed(coef_data);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    y_d     = y_q;
    phase_d = phase_q ^ in_en;

    case (state_q)
      StIdle: begin
        if (trigger) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + AW'(prod);
        if (k_q == KLast) begin
          state_d = StCtr;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StCtr: begin
        acc_d   = acc_q + ctr_term;
        state_d = StOut;
      end
      StOut: begin
        if (y_valid) begin
          y_d = y_next;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Overrun: the sample is still shifted in, but the running computation is dropped.
    if (busy && in_en) begin
      ovf_d = 1'b1;
      if (trigger) begin
        acc_d   = '0;
        k_d     = '0;
        state_d = StMac;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
      end
      for (int i = 0; i < K; i++) begin
        c_q[i] <= '0;
      end
      state_q <= StIdle;
      k_q     <= '0;
      acc_q   <= '0;
      phase_q <= 1'b0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (in_en) begin
        x_q[0] <= $signed(x_in);
        for (int i = 1; i < NTAPS; i++) begin
          x_q[i] <= x_q[i-1];
        end
      end
      c_q     <= c_d;
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      phase_q <= phase_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_halfband_decim_ts.sv
// Testbench for halfband_decim_ts (NTAPS=11, K=3, 18-bit data and coefficients).
// Expected outputs are hand-computed and queued with their required strobe cycle; a monitor
// on the falling edge pops and compares every y_valid.
module tb_halfband_decim_ts;

  localparam int K   = 3;
  localparam int LAT = K + 2;

`ifdef HB_DECIM_SAT_EN
  localparam int SAT_EXP = 131071;
`else
  localparam int SAT_EXP = -76610;
`endif

  logic               sys_clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_en = 1'b0;
  logic signed [17:0] x_in = '0;
  logic               coef_wr = 1'b0;
  logic [1:0]         coef_addr = '0;
  logic signed [17:0] coef_data = '0;
  logic signed [17:0] y;
  logic               y_valid;
  logic               busy;
  logic               ovf;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  halfband_decim_ts #(
    .WIDTH  (18),
    .CWIDTH (18),
    .NTAPS  (11)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .in_en     (in_en),
    .x_in      (x_in),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .y         (y),
    .y_valid   (y_valid),
    .busy      (busy),
    .ovf       (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: every strobe must match the oldest queued expectation, value and cycle.
  always @(negedge sys_clk) begin
    if (y_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected y_valid", int'(y_valid), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("y value", int'(y), e.val);
        check("y latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_y(int v);
    exp_q.push_back('{v, cyc + LAT});
  endtask

  // One input sample followed by idle cycles (spacing 8 >= K+3).
  task automatic pulse(int xv, bit has_exp, int ev);
    in_en = 1'b1;
    x_in  = xv[17:0];
    if (has_exp) expect_y(ev);
    step();
    in_en   = 1'b0;
    x_in    = '0;
    coef_wr = 1'b0;
    repeat (7) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic load(int a, int d);
    coef_wr   = 1'b1;
    coef_addr = a[1:0];
    coef_data = d[17:0];
    step();
    coef_wr = 1'b0;
  endtask

  int dc_exp[8] = '{250, -2000, 24576, 34768, 32518, 32768, 32768, 32768};
  int imp_exp[7] = '{500, -4500, 20384, 20384, -4500, 500, 0};
  int nt_exp[4] = '{0, 0, 32768, 0};

  initial begin
    step();
    do_reset();
    @(negedge sys_clk);
    check("reset y", int'(y), 0);
    check("reset busy", int'(busy), 0);
    check("reset ovf", int'(ovf), 0);
    check("reset y_valid", int'(y_valid), 0);
    step();

    // DC gain: transient outputs, then unity gain once the delay line is full.
    load(0, 1000);
    load(1, -9000);
    load(2, 40768);
    load(3, 12345);
    for (int i = 1; i <= 16; i++) begin
      if (i % 2 == 0) pulse(32768, 1'b1, dc_exp[i/2-1]);
      else pulse(32768, 1'b0, 0);
    end
    @(negedge sys_clk);
    check("dc ovf", int'(ovf), 0);
    step();

    // Impulse on the trigger phase; c[0] is written together with the first trigger.
    do_reset();
    load(1, -9000);
    load(2, 40768);
    pulse(0, 1'b0, 0);
    for (int i = 2; i <= 14; i++) begin
      if (i == 2) begin
        coef_wr   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 18'sd1000;
      end
      if (i % 2 == 0) pulse((i == 2) ? 65536 : 0, 1'b1, imp_exp[i/2-1]);
      else pulse(0, 1'b0, 0);
    end

    // Impulse on the non-trigger phase: only the centre tap sees it.
    do_reset();
    load(0, 1000);
    load(1, -9000);
    load(2, 40768);
    pulse(65536, 1'b0, 0);
    for (int i = 2; i <= 8; i++) begin
      if (i % 2 == 0) pulse(0, 1'b1, nt_exp[i/2-1]);
      else pulse(0, 1'b0, 0);
    end

    // Overrun: in_en 2 clocks after a trigger aborts it; coef_wr while busy is ignored.
    do_reset();
    load(0, 1000);
    load(1, -9000);
    load(2, 40768);
    pulse(0, 1'b0, 0);
    in_en = 1'b1;
    x_in  = '0;
    step();
    in_en     = 1'b0;
    coef_wr   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 18'sd7777;
    @(negedge sys_clk);
    check("busy in MAC", int'(busy), 1);
    step();
    coef_wr = 1'b0;
    in_en   = 1'b1;
    x_in    = '0;
    step();
    in_en = 1'b0;
    repeat (8) step();
    @(negedge sys_clk);
    check("ovf after abort", int'(ovf), 1);
    check("busy after abort", int'(busy), 0);
    step();
    pulse(65536, 1'b1, 500);
    @(negedge sys_clk);
    check("ovf sticky", int'(ovf), 1);
    step();

    // in_en in the OUT cycle suppresses the output.
    do_reset();
    load(0, 1000);
    pulse(0, 1'b0, 0);
    in_en = 1'b1;
    x_in  = 18'sd65536;
    step();
    in_en = 1'b0;
    x_in  = '0;
    repeat (4) step();
    in_en = 1'b1;
    @(negedge sys_clk);
    check("busy in OUT", int'(busy), 1);
    check("y_valid suppressed", int'(y_valid), 0);
    step();
    in_en = 1'b0;
    repeat (6) step();
    @(negedge sys_clk);
    check("ovf after OUT hit", int'(ovf), 1);
    check("y held after suppress", int'(y), 0);
    step();

    // Saturation / wrap with a large held input.
    do_reset();
    load(2, 60000);
    for (int i = 1; i <= 10; i++) begin
      case (i)
        2, 4:    pulse(131071, 1'b1, 0);
        6:       pulse(131071, 1'b1, 125535);
        8, 10:   pulse(131071, 1'b1, SAT_EXP);
        default: pulse(131071, 1'b0, 0);
      endcase
    end

    // Reset mid-MAC after making y and ovf non-zero.
    do_reset();
    load(0, 1000);
    load(1, -9000);
    load(2, 40768);
    pulse(0, 1'b0, 0);
    pulse(65536, 1'b1, 500);
    pulse(0, 1'b0, 0);
    in_en = 1'b1;
    x_in  = '0;
    step();
    in_en = 1'b0;
    step();
    in_en = 1'b1;
    step();
    in_en = 1'b0;
    repeat (7) step();
    pulse(0, 1'b1, 20384);
    pulse(0, 1'b0, 0);
    @(negedge sys_clk);
    check("ovf before reset", int'(ovf), 1);
    step();
    in_en = 1'b1;
    x_in  = '0;
    step();
    in_en = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge sys_clk);
    check("mid reset y", int'(y), 0);
    check("mid reset busy", int'(busy), 0);
    check("mid reset ovf", int'(ovf), 0);
    check("mid reset y_valid", int'(y_valid), 0);
    step();
    repeat (8) step();
    // Coefficients must be cleared: an impulse now yields zeros.
    pulse(0, 1'b0, 0);
    pulse(65536, 1'b1, 0);
    pulse(0, 1'b0, 0);
    pulse(0, 1'b1, 0);
    pulse(0, 1'b0, 0);
    pulse(0, 1'b1, 0);

    repeat (10) step();
    check("expected outputs drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
